// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
// Holds the handshake FSM encoding and the source index width helper.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2
    } irq_state_t;

    localparam int TIMER_SRC = 0;

    function automatic int id_width(input int num_src);
        return $clog2(num_src + 1);
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Request/acknowledge/completion handshake between the interrupt
// controller (master) and the core's trap logic (slave).
interface irq_controller_if #(
    parameter int ID_W = 3
);

    logic            irq_valid;
    logic [ID_W-1:0] irq_id;
    logic            irq_ack;
    logic            irq_done;

    modport master (
        output irq_valid,
        output irq_id,
        input  irq_ack,
        input  irq_done
    );

    modport slave (
        input  irq_valid,
        input  irq_id,
        output irq_ack,
        output irq_done
    );

endinterface

// File: rtl/cmp_timer.sv
// Free-running compare timer feeding interrupt source 0.
// Wraps to zero on terminal count and flags the wrap one cycle later.
module cmp_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               timer_en,
    input  logic [TIMER_W-1:0] timer_cmp,
    output logic               hit,
    output logic               timer_ovf
);

    logic [TIMER_W-1:0] count;

    // Terminal count only matters while the timer is running.
    assign hit = timer_en && (count == timer_cmp);

    // Count, wrap on terminal count, register the overflow pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            timer_ovf <= 1'b0;
        end else begin
            timer_ovf <= hit;
            if (hit) begin
                count <= '0;
            end else if (timer_en) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: synchronises external lines, latches pending,
// arbitrates by fixed priority and runs the valid/ack/done handshake.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMER_W     = 16,
    localparam int ID_W       = id_width(NUM_SRC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC-1:0]    src_i,
    input  logic [NUM_SRC:0]      src_edge_mode,
    input  logic [NUM_SRC:0]      src_en,
    input  logic                  timer_en,
    input  logic [TIMER_W-1:0]    timer_cmp,
    irq_controller_if.master      irq_bus,
    output logic [NUM_SRC:0]      pending,
    output logic                  timer_ovf
);

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] lvl;
    logic [NUM_SRC-1:0] prev_q;
    logic               timer_hit;
    logic [NUM_SRC:0]   edge_mask;
    logic [NUM_SRC:0]   set_vec;
    logic [NUM_SRC:0]   clr_vec;
    logic [NUM_SRC:0]   pending_d;
    logic [NUM_SRC:0]   eligible;
    logic               any_elig;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    id_q;
    logic               ack_take;
    irq_state_t         state_q;
    irq_state_t         state_d;

    cmp_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .timer_en  (timer_en),
        .timer_cmp (timer_cmp),
        .hit       (timer_hit),
        .timer_ovf (timer_ovf)
    );

    // Synchroniser chain plus one flop of history for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= src_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= lvl;
        end
    end

    assign lvl = sync_q[SYNC_STAGES-1];

    // The timer is edge-only whatever its mode bit says.
    assign edge_mask = {src_edge_mode[NUM_SRC:1],
                        src_edge_mode[TIMER_SRC] | 1'b1};
    assign set_vec   = {lvl & ~prev_q, timer_hit};
    assign ack_take  = (state_q == REQ) && irq_bus.irq_ack;
    assign clr_vec   = ack_take ? ((NUM_SRC+1)'(1) << id_q) : '0;

    // Edge bits: set beats clear. Level bits: follow the synced line.
    assign pending_d = (edge_mask & (set_vec | (pending & ~clr_vec)))
                     | (~edge_mask & {lvl, 1'b0});

    // Pending register accumulates in every FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_d;
        end
    end

    assign eligible = pending & src_en;
    assign any_elig = |eligible;

    // Fixed priority: lowest index wins, so scan downwards.
    always_comb begin
        win_id = '0;
        for (int k = NUM_SRC; k >= 0; k--) begin
            if (eligible[k]) begin
                win_id = ID_W'(k);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: ack wins over a simultaneous done in REQ.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_elig)         state_d = REQ;
            REQ:     if (irq_bus.irq_ack)  state_d = ACTIVE;
            ACTIVE:  if (irq_bus.irq_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request is a pure decode of the registered state.
    always_comb begin
        irq_bus.irq_valid = (state_q == REQ);
        irq_bus.irq_id    = id_q;
    end

    // Winner is captured only when leaving IDLE, then frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q <= '0;
        end else if ((state_q == IDLE) && any_elig) begin
            id_q <= win_id;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus random traffic,
// every cycle compared against a history-based reference model.
module tb_irq_controller;

    localparam int NS = 4;
    localparam int SS = 2;
    localparam int TW = 16;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] src_i;
    logic [NS:0]   src_edge_mode;
    logic [NS:0]   src_en;
    logic          timer_en;
    logic [TW-1:0] timer_cmp;
    logic [NS:0]   pending;
    logic          timer_ovf;

    irq_controller_if #(.ID_W(IW)) bus ();

    irq_controller #(
        .NUM_SRC     (NS),
        .SYNC_STAGES (SS),
        .TIMER_W     (TW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .src_i         (src_i),
        .src_edge_mode (src_edge_mode),
        .src_en        (src_en),
        .timer_en      (timer_en),
        .timer_cmp     (timer_cmp),
        .irq_bus       (bus),
        .pending       (pending),
        .timer_ovf     (timer_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: src history per edge, timer count, pending,
    // handshake phase (0 idle, 1 requesting, 2 in service) and id.
    logic [NS-1:0] hist[$];
    int            m_cnt;
    logic          m_ovf;
    logic [NS:0]   m_pend;
    int            m_st;
    int            m_id;

    function automatic logic [NS-1:0] h_at(input int i);
        if (i < 0 || i >= hist.size()) return '0;
        return hist[i];
    endfunction

    task automatic model_reset();
        hist.delete();
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_pend = '0;
        m_st   = 0;
        m_id   = 0;
    endtask

    // Apply one clock edge to the model using the driven inputs.
    task automatic model_edge();
        logic [NS-1:0] lv;
        logic [NS-1:0] pv;
        logic [NS:0]   elig;
        logic [NS:0]   nxt;
        logic          hit;
        logic          s;
        int            n;
        hist.push_back(src_i);
        n    = hist.size() - 1;
        lv   = h_at(n - SS);
        pv   = h_at(n - SS - 1);
        hit  = timer_en && (m_cnt == int'(timer_cmp));
        elig = m_pend & src_en;
        nxt  = m_pend;
        for (int k = 0; k <= NS; k++) begin
            s = (k == 0) ? hit : (lv[k-1] && !pv[k-1]);
            if (k == 0 || src_edge_mode[k]) begin
                if (m_st == 1 && bus.irq_ack && m_id == k) nxt[k] = 1'b0;
                if (s) nxt[k] = 1'b1;
            end else begin
                nxt[k] = lv[k-1];
            end
        end
        if (m_st == 0) begin
            if (elig != '0) begin
                m_st = 1;
                for (int k = 0; k <= NS; k++) begin
                    if (elig[k]) begin
                        m_id = k;
                        break;
                    end
                end
            end
        end else if (m_st == 1) begin
            if (bus.irq_ack) m_st = 2;
        end else begin
            if (bus.irq_done) m_st = 0;
        end
        m_ovf = hit;
        if (hit) m_cnt = 0;
        else if (timer_en) m_cnt = m_cnt + 1;
        m_pend = nxt;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("valid", 32'(bus.irq_valid), 32'(m_st == 1));
        check("id", 32'(bus.irq_id), m_id);
        check("pending", 32'(pending), 32'(m_pend));
        check("ovf", 32'(timer_ovf), 32'(m_ovf));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic handshake();
        bus.irq_ack  = 1'b1;
        step();
        bus.irq_ack  = 1'b0;
        bus.irq_done = 1'b1;
        step();
        bus.irq_done = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic idle_inputs();
        src_i         = '0;
        src_edge_mode = '1;
        src_en        = '1;
        timer_en      = 1'b0;
        timer_cmp     = '0;
        bus.irq_ack   = 1'b0;
        bus.irq_done  = 1'b0;
    endtask

    int ovfs;

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.irq_valid), 0);
        check("rst_id", 32'(bus.irq_id), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_ovf", 32'(timer_ovf), 0);
        rst = 1'b0;

        // Timer period and ack clearing source 0.
        timer_cmp = 16'd3;
        timer_en  = 1'b1;
        ovfs      = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            ovfs += int'(timer_ovf);
        end
        check("t1_ovf_count", ovfs, 4);
        check("t1_id0", 32'(bus.irq_id), 0);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        check("t1_ack_clr", 32'(pending[0]), 0);
        bus.irq_done = 1'b1;
        timer_en     = 1'b0;
        step();
        bus.irq_done = 1'b0;
        idle_inputs();
        reset_dut();

        // Edge on source 2: three cycles to pending, one more to valid.
        src_i = 4'b0010;
        run(2);
        check("t2_pend_early", 32'(pending[2]), 0);
        step();
        check("t2_pend", 32'(pending[2]), 1);
        check("t2_valid_early", 32'(bus.irq_valid), 0);
        step();
        check("t2_valid", 32'(bus.irq_valid), 1);
        check("t2_id", 32'(bus.irq_id), 2);
        handshake();
        src_i = '0;
        run(4);

        // Sources 1 and 3 together, timer arriving during REQ.
        src_i = 4'b0101;
        run(4);
        check("t3_id1", 32'(bus.irq_id), 1);
        timer_en = 1'b1;
        step();
        timer_en = 1'b0;
        step();
        check("t3_frozen", 32'(bus.irq_id), 1);
        check("t3_p0", 32'(pending[0]), 1);
        handshake();
        step();
        check("t3_id0", 32'(bus.irq_id), 0);
        handshake();
        step();
        check("t3_id3", 32'(bus.irq_id), 3);
        handshake();
        src_i = '0;
        run(4);

        // Level source 1: re-request after done, none once dropped.
        src_edge_mode[1] = 1'b0;
        src_i = 4'b0001;
        run(4);
        check("t4_id1", 32'(bus.irq_id), 1);
        handshake();
        step();
        check("t4_rereq", 32'(bus.irq_valid), 1);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        src_i = '0;
        run(3);
        bus.irq_done = 1'b1;
        step();
        bus.irq_done = 1'b0;
        step();
        check("t4_no_rereq", 32'(bus.irq_valid), 0);
        src_edge_mode = '1;
        run(2);

        // Second edge landing in the ack cycle is not lost.
        src_i = 4'b0010;
        step();
        src_i = '0;
        step();
        src_i = 4'b0010;
        run(2);
        check("t5_id2", 32'(bus.irq_id), 2);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        check("t5_keep", 32'(pending[2]), 1);
        bus.irq_done = 1'b1;
        step();
        bus.irq_done = 1'b0;
        step();
        check("t5_second", 32'(bus.irq_valid), 1);
        handshake();
        src_i = '0;
        run(4);

        // Async reset mid-REQ, then stray ack/done.
        src_i = 4'b0001;
        run(4);
        #2;
        rst = 1'b1;
        #1;
        check("t6_valid", 32'(bus.irq_valid), 0);
        check("t6_pending", 32'(pending), 0);
        check("t6_ovf", 32'(timer_ovf), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        src_i = '0;
        run(4);
        src_i = 4'b0100;
        run(4);
        bus.irq_ack = 1'b1;
        step();
        step();
        bus.irq_ack  = 1'b0;
        check("t6_active", 32'(bus.irq_valid), 0);
        bus.irq_done = 1'b1;
        run(3);
        bus.irq_done = 1'b0;
        src_i = '0;
        run(4);

        // Random traffic against the model.
        for (int r = 0; r < 6; r++) begin
            idle_inputs();
            reset_dut();
            timer_cmp     = TW'($urandom_range(0, 15));
            src_edge_mode = (NS+1)'($urandom);
            src_en        = (NS+1)'($urandom | $urandom);
            for (int c = 0; c < 400; c++) begin
                for (int b = 0; b < NS; b++) begin
                    if ($urandom_range(0, 7) == 0) src_i[b] = ~src_i[b];
                end
                if ($urandom_range(0, 31) == 0) begin
                    src_en[$urandom_range(0, NS)] ^= 1'b1;
                end
                timer_en = ($urandom_range(0, 9) != 0);
                bus.irq_ack = (m_st == 1) ? 1'($urandom_range(0, 1))
                                          : ($urandom_range(0, 15) == 0);
                bus.irq_done = (m_st == 2) ? ($urandom_range(0, 2) == 0)
                                           : ($urandom_range(0, 15) == 0);
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
